sop_pipe_reg: RTL and testbench
===============================

# sop_pipe_reg

Parametrised, pipelined successor to the team's single-bit registered AND-OR cell. It evaluates a selectable two-level logic function over four W-bit operand vectors, bit-wise, in a two-stage pipeline with valid/ready flow control on both sides. It also keeps a saturating count of non-zero results. It sits between operand producers and a result consumer that may stall.

## Interface
Parameters:
- W, default 4: operand/result width in bits (≥1).
- CNT_W, default 8: hit-counter width (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a, b, c, d  in  W each  operand vectors.
- mode  in  2  function select, captured with the operands.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept this cycle.
- f  out  W  result.
- out_valid  out  1  f is valid.
- out_ready  in  1  consumer accepts f.
- cnt_clr  in  1  synchronous clear of hit counter.
- hit_cnt  out  CNT_W  count of accepted non-zero results.

## Operation
- Functions, bit-wise per mode:
  - 00: f = (a&b)|(c&d).
  - 01: f = (a|b)&(c|d).
  - 10: f = (a^b)|(c^d).
  - 11: f = ~((a&b)|(c&d)).
- Stage 1 (S1) registers:
  - p = op1(a,b) and q = op1(c,d), where op1 is AND for modes 00/11, OR for 01, XOR for 10.
  - mode, and valid bit s1_v.
- Stage 2 (S2) registers:
  - f = op2(p,q), where op2 is OR for 00/10, AND for 01, NOR for 11.
  - valid bit s2_v, which drives out_valid.
- Mode travels with its data. Changing mode between beats affects only the beats that carry it.
- Enables:
  - s2_en = ~s2_v | out_ready.
  - s1_en = ~s1_v | s2_en.
  - in_ready = s1_en.
- Transfers:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
- When s2_en is high:
  - S2 loads from S1.
  - s2_v takes s1_v.
- When s1_en is high:
  - S1 loads the inputs.
  - s1_v takes in_valid & in_ready.
- When an enable is low, that stage holds its data and valid bit unchanged.
- No beat is dropped or duplicated.
- Counter:
  - hit_cnt increments on an output transfer with |f = 1.
  - Saturates at 2^CNT_W−1.
  - cnt_clr forces 0 and takes priority over a same-cycle increment.
- in_ready is combinational from out_ready through the enables. There is no other combinational input-to-output path.

## Timing
- Reset (rst=1 at an edge) clears state:
  - s1_v = 0, s2_v = 0, so out_valid = 0.
  - f = 0, hit_cnt = 0, stored p/q/mode = 0.
- During reset, in_ready follows the enable equations; any input transfer in that cycle is discarded.
- A reset mid-stream discards all in-flight beats. No output transfer is counted on the reset edge.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1, provided S2 was free.
- Throughput: one beat per cycle while out_ready=1.
- Stall (out_ready=0 with out_valid=1):
  - f and out_valid hold stable.
  - S1 can absorb one more beat, then in_ready drops.
  - in_ready rises in the same cycle out_ready returns high.
- Simultaneous input and output transfer on a full pipe: both stages advance and occupancy is unchanged.
- Counter wrap: at 2^CNT_W−1 a further hit leaves the value unchanged; it never wraps to 0.

## Test plan
- Reset and idle: hold rst=1 for 2 cycles, then release → out_valid=0, f=0, hit_cnt=0, in_ready=1.
- Modes, with W=4, a=1100, b=1010, c=0011, d=0110, out_ready=1, one beat per mode 00/01/10/11 on consecutive cycles:
  - Required f sequence 1010, 0110, 0111, 0101.
  - Each result appears 2 cycles after its input.
  - hit_cnt ends at 4.
- Back-pressure: stream 6 beats while holding out_ready=0 for 4 cycles mid-stream:
  - in_ready falls after 2 beats are buffered.
  - f holds constant.
  - All 6 results emerge in order with none lost.
- Zero results: mode 00 with a=b=c=d=0000 → f=0000 accepted, hit_cnt unchanged. Mode 11 with the same operands → f=1111, hit_cnt+1.
- Counter edge cases, with CNT_W=2:
  - 5 non-zero accepted outputs → hit_cnt=3 (saturated).
  - cnt_clr asserted together with a hit → hit_cnt=0.
- Reset mid-operation: assert rst while both stages are valid → next cycle out_valid=0, and the in-flight beats never appear.

Source files
------------

// File: rtl/sop_pipe_reg.sv
// sop_pipe_reg: two-stage pipelined, mode-selectable bit-wise AND-OR function with
// valid/ready flow control on both sides and a saturating count of non-zero results.
module sop_pipe_reg #(
  parameter int W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic [W-1:0]     d,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     f,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt
);
  logic [W-1:0] r_p, r_q, r_f, w_p, w_q, w_f;
  logic [1:0] r_mode;
  logic r_s1_v, r_s2_v, w_s1_en, w_s2_en, w_hit;
  logic [CNT_W-1:0] r_cnt;
  always_comb begin
    w_s2_en = ~r_s2_v | out_ready;
    w_s1_en = ~r_s1_v | w_s2_en;
    w_p = (mode == 2'b01) ? a | b : (mode == 2'b10) ? a ^ b : a & b;
    w_q = (mode == 2'b01) ? c | d : (mode == 2'b10) ? c ^ d : c & d;
    w_f = (r_mode == 2'b01) ? r_p & r_q : (r_mode == 2'b11) ? ~(r_p | r_q) : r_p | r_q;
    w_hit = r_s2_v & out_ready & (|r_f);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p <= '0;
      r_q <= '0;
      r_mode <= '0;
      r_s1_v <= 1'b0;
      r_f <= '0;
      r_s2_v <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_s2_en) begin
        r_f <= w_f;
        r_s2_v <= r_s1_v;
      end
      if (w_s1_en) begin
        r_p <= w_p;
        r_q <= w_q;
        r_mode <= mode;
        r_s1_v <= in_valid;
      end
      // clear wins over a same-cycle hit; the all-ones value is sticky
      r_cnt <= cnt_clr ? '0 : (w_hit && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    end
  end
  assign in_ready = w_s1_en;
  assign f = r_f;
  assign out_valid = r_s2_v;
  assign hit_cnt = r_cnt;
endmodule

// File: tb/tb_sop_pipe_reg.sv
// tb_sop_pipe_reg: table vectors, hand-written stall/reset/counter sequences and random
// traffic, all checked against an in-order queue model of the pipeline.
module tb_sop_pipe_reg;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
  logic [1:0] mode = '0;
  logic in_valid = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [W-1:0] f, f2;
  logic [7:0] hit8;
  logic [1:0] hit2;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  sop_pipe_reg #(.W(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .f(f), .out_valid(out_valid),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .hit_cnt(hit8)
  );

  sop_pipe_reg #(.W(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready2), .f(f2), .out_valid(out_valid2),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .hit_cnt(hit2)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, want);
  endtask

  function automatic logic [W-1:0] ref_f(input logic [1:0] m, input logic [W-1:0] x0, x1, x2, x3);
    case (m)
      2'b00: return (x0 & x1) | (x2 & x3);
      2'b01: return (x0 | x1) & (x2 | x3);
      2'b10: return (x0 ^ x1) | (x2 ^ x3);
      default: return ~((x0 & x1) | (x2 & x3));
    endcase
  endfunction

  // Reference model: beats in flight, in acceptance order, with the edge that accepted them.
  typedef struct {logic [W-1:0] f; int acc;} beat_t;
  beat_t q[$];
  int cyc = 0, c8 = 0, c2 = 0;
  bit primed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic eov, eir;
    eov = 1'b0;
    eir = 1'b0;
    if (primed) begin
      eov = q.size() > 0 && cyc >= q[0].acc + 1;
      eir = q.size() < 2 || out_ready;
      chk("out_valid", out_valid, eov);
      chk("in_ready", in_ready, eir);
      chk("out_valid_c2", out_valid2, eov);
      chk("in_ready_c2", in_ready2, eir);
      chk("hit_cnt8", hit8, c8);
      chk("hit_cnt2", hit2, c2);
      if (eov) begin
        chk("f", f, q[0].f);
        chk("f_c2", f2, q[0].f);
      end
    end
    if (rst) begin
      q.delete();
      c8 = 0;
      c2 = 0;
      primed = 1'b1;
    end else if (primed) begin
      if (cnt_clr) begin
        c8 = 0;
        c2 = 0;
      end else if (eov && out_ready && q[0].f != 0) begin
        c8 = (c8 < 255) ? c8 + 1 : 255;
        c2 = (c2 < 3) ? c2 + 1 : 3;
      end
      if (eov && out_ready) void'(q.pop_front());
      if (in_valid && eir) q.push_back('{ref_f(mode, a, b, c, d), cyc + 1});
    end
  end

  typedef struct {logic [1:0] mode; logic [W-1:0] a, b, c, d, want;} vec_t;
  vec_t tbl[6];
  logic [17:0] bp_in[6];
  logic [W-1:0] bp_exp[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    mode = v.mode;
    a = v.a;
    b = v.b;
    c = v.c;
    d = v.d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, rcv;
    logic [W-1:0] f_hold;
    tbl[0] = '{2'b00, 4'b1100, 4'b1010, 4'b0011, 4'b0110, 4'b1010};
    tbl[1] = '{2'b01, 4'b1100, 4'b1010, 4'b0011, 4'b0110, 4'b0110};
    tbl[2] = '{2'b10, 4'b1100, 4'b1010, 4'b0011, 4'b0110, 4'b0111};
    tbl[3] = '{2'b11, 4'b1100, 4'b1010, 4'b0011, 4'b0110, 4'b0101};
    tbl[4] = '{2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[5] = '{2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111};

    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_f", f, 0);
    chk("reset_hit_cnt", hit8, 0);
    chk("reset_in_ready", in_ready, 1);
    tick();

    // one beat per cycle; each result expected two edges after it was presented
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(tbl[i]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (i >= 2) begin
        chk("tbl_out_valid", out_valid, 1);
        chk("tbl_f", f, tbl[i-2].want);
      end
      tick();
    end
    @(negedge clk);
    chk("tbl_hit_cnt8", hit8, 5);
    chk("tbl_hit_cnt2_sat", hit2, 3);
    tick();

    drive(tbl[5]);
    tick();
    in_valid = 1'b0;
    tick();
    cnt_clr = 1'b1;
    @(negedge clk);
    chk("clr_out_valid", out_valid, 1);
    tick();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_hit_cnt8", hit8, 0);
    chk("clr_hit_cnt2", hit2, 0);
    tick();

    for (int i = 0; i < 6; i++) begin
      bp_in[i] = 18'($urandom);
      bp_exp[i] = ref_f(bp_in[i][17:16], bp_in[i][15:12], bp_in[i][11:8], bp_in[i][7:4], bp_in[i][3:0]);
    end
    k = 0;
    rcv = 0;
    f_hold = '0;
    for (int t = 0; t < 30 && rcv < 6; t++) begin
      in_valid = (k < 6);
      if (k < 6) {mode, a, b, c, d} = bp_in[k];
      out_ready = !(t >= 2 && t <= 5);
      @(negedge clk);
      if (t == 2) f_hold = f;
      if (t >= 2 && t <= 5) begin
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid_hold", out_valid, 1);
        chk("bp_f_hold", f, f_hold);
      end
      if (t == 6) chk("bp_in_ready_rise", in_ready, 1);
      if (out_valid && out_ready) begin
        chk("bp_order", f, bp_exp[rcv]);
        rcv++;
      end
      if (in_valid && in_ready) k++;
      tick();
    end
    chk("bp_count", rcv, 6);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    out_ready = 1'b0;
    drive(tbl[0]);
    tick();
    drive(tbl[2]);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_full_valid", out_valid, 1);
    chk("rst_mid_full_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_flush_valid", out_valid, 0);
      tick();
    end
    chk("rst_hit_cnt", hit8, 0);

    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      c = 4'($urandom);
      d = 4'($urandom);
      cnt_clr = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    cnt_clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("drain_empty", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
